// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg : ID/EX pipeline register of the 5-stage RV32 core.
//
// Captures the decoded control bits, register read data, sign-extended
// immediate, funct bits, register indices and PC of the instruction in ID, and
// presents them to EX one cycle later. It supports three kinds of disturbance:
//   - stall_i : data-cache stall, the register holds its contents.
//   - flush_i : branch-taken flush, a bubble replaces the instruction in ID.
//               A flush seen during a stall is remembered in r_flush_pend and
//               turned into a bubble on the first non-stalled edge.
//   - nop_i   : load-use bubble from hazard detection.
// A bubble clears every output to zero, so RegWrite/MemRead/MemWrite are 0
// and rd_addr is x0, which the forwarding unit can never match.
//
// Ports:
//   clk_i, rst_i (sync, active-high), stall_i, flush_i, nop_i, valid_i
//   RegWrite/MemtoReg/MemRead/MemWrite/ALUSrc (1b), ALUOp (2b)
//   rs1_data/rs2_data/imm/pc (XLEN), funct (10b, {funct7, funct3})
//   rs1_addr/rs2_addr/rd_addr (REG_AW)
//   *_o : registered copies of the above, plus valid_o and flush_pend_o.
//
// Optional feature (macro ID_EX_WB_BYPASS_EN):
//   Adds wb_we_i / wb_rd_i / wb_data_i for register-file write-through. On a
//   load edge, a write-back to a non-zero register that matches rs1_addr_i
//   (or rs2_addr_i) replaces the stale read data with wb_data_i.
// -----------------------------------------------------------------------------
module id_ex_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              nop_i,
  input  logic              valid_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              ALUSrc_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [9:0]        funct_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [XLEN-1:0]   pc_i,
`ifdef ID_EX_WB_BYPASS_EN
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
`endif
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              ALUSrc_o,
  output logic [1:0]        ALUOp_o,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [9:0]        funct_o,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic [XLEN-1:0]   pc_o,
  output logic              valid_o,
  output logic              flush_pend_o
);

  logic              r_RegWrite;
  logic              r_MemtoReg;
  logic              r_MemRead;
  logic              r_MemWrite;
  logic              r_ALUSrc;
  logic [1:0]        r_ALUOp;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [9:0]        r_funct;
  logic [REG_AW-1:0] r_rs1_addr;
  logic [REG_AW-1:0] r_rs2_addr;
  logic [REG_AW-1:0] r_rd_addr;
  logic [XLEN-1:0]   r_pc;
  logic              r_valid;
  logic              r_flush_pend;

  logic              w_bubble;
  logic [XLEN-1:0]   w_rs1_data;
  logic [XLEN-1:0]   w_rs2_data;

  // A pending flush and a new flush on the release edge collapse into the
  // same single bubble because both feed this one OR.
  assign w_bubble = flush_i | r_flush_pend | nop_i | ~valid_i;

`ifdef ID_EX_WB_BYPASS_EN
  // Write-through: the register file is read in the same cycle that WB
  // writes it, so the read data may be stale. x0 is never bypassed.
  assign w_rs1_data = (wb_we_i && (wb_rd_i != '0) && (wb_rd_i == rs1_addr_i))
                      ? wb_data_i : rs1_data_i;
  assign w_rs2_data = (wb_we_i && (wb_rd_i != '0) && (wb_rd_i == rs2_addr_i))
                      ? wb_data_i : rs2_data_i;
`else
  assign w_rs1_data = rs1_data_i;
  assign w_rs2_data = rs2_data_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i || (!stall_i && w_bubble)) begin
      r_RegWrite   <= 1'b0;
      r_MemtoReg   <= 1'b0;
      r_MemRead    <= 1'b0;
      r_MemWrite   <= 1'b0;
      r_ALUSrc     <= 1'b0;
      r_ALUOp      <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_funct      <= '0;
      r_rs1_addr   <= '0;
      r_rs2_addr   <= '0;
      r_rd_addr    <= '0;
      r_pc         <= '0;
      r_valid      <= 1'b0;
      r_flush_pend <= 1'b0;
    end else if (stall_i) begin
      // Fields hold; only remember a flush so it is not lost.
      r_flush_pend <= r_flush_pend | flush_i;
    end else begin
      r_RegWrite   <= RegWrite_i;
      r_MemtoReg   <= MemtoReg_i;
      r_MemRead    <= MemRead_i;
      r_MemWrite   <= MemWrite_i;
      r_ALUSrc     <= ALUSrc_i;
      r_ALUOp      <= ALUOp_i;
      r_rs1_data   <= w_rs1_data;
      r_rs2_data   <= w_rs2_data;
      r_imm        <= imm_i;
      r_funct      <= funct_i;
      r_rs1_addr   <= rs1_addr_i;
      r_rs2_addr   <= rs2_addr_i;
      r_rd_addr    <= rd_addr_i;
      r_pc         <= pc_i;
      r_valid      <= 1'b1;
      r_flush_pend <= 1'b0;
    end
  end

  assign RegWrite_o   = r_RegWrite;
  assign MemtoReg_o   = r_MemtoReg;
  assign MemRead_o    = r_MemRead;
  assign MemWrite_o   = r_MemWrite;
  assign ALUSrc_o     = r_ALUSrc;
  assign ALUOp_o      = r_ALUOp;
  assign rs1_data_o   = r_rs1_data;
  assign rs2_data_o   = r_rs2_data;
  assign imm_o        = r_imm;
  assign funct_o      = r_funct;
  assign rs1_addr_o   = r_rs1_addr;
  assign rs2_addr_o   = r_rs2_addr;
  assign rd_addr_o    = r_rd_addr;
  assign pc_o         = r_pc;
  assign valid_o      = r_valid;
  assign flush_pend_o = r_flush_pend;

endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg : directed self-checking bench for id_ex_reg.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. after the edge that consumed the previous inputs.
// Build with +define+ID_EX_WB_BYPASS_EN to also exercise write-through.
// -----------------------------------------------------------------------------
module tb_id_ex_reg;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i, nop_i, valid_i;
  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
  logic [1:0]  ALUOp_i;
  logic [31:0] rs1_data_i, rs2_data_i, imm_i, pc_i;
  logic [9:0]  funct_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
`ifdef ID_EX_WB_BYPASS_EN
  logic        wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
`endif
  logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o;
  logic [1:0]  ALUOp_o;
  logic [31:0] rs1_data_o, rs2_data_o, imm_o, pc_o;
  logic [9:0]  funct_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic        valid_o, flush_pend_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  id_ex_reg #(.XLEN(32), .REG_AW(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .nop_i(nop_i), .valid_i(valid_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .funct_i(funct_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rd_addr_i(rd_addr_i), .pc_i(pc_i),
`ifdef ID_EX_WB_BYPASS_EN
    .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
`endif
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
    .funct_o(funct_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rd_addr_o(rd_addr_o), .pc_o(pc_o),
    .valid_o(valid_o), .flush_pend_o(flush_pend_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  // 1 when any output bit is non-zero (or unknown).
  function automatic logic any_out();
    return |{RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
             rs1_data_o, rs2_data_o, imm_o, funct_o, rs1_addr_o, rs2_addr_o,
             rd_addr_o, pc_o, valid_o, flush_pend_o} !== 1'b0;
  endfunction

  initial begin
    // Reset with busy-looking inputs so clearing is really observed.
    rst_i = 1; stall_i = 0; flush_i = 0; nop_i = 0; valid_i = 1;
    RegWrite_i = 1; MemtoReg_i = 1; MemRead_i = 0; MemWrite_i = 1; ALUSrc_i = 1;
    ALUOp_i = 2'd2; rs1_data_i = 32'h1111_1111; rs2_data_i = 32'h2222_2222;
    imm_i = 32'hFFFF_F800; funct_i = 10'h2A5; rs1_addr_i = 5'd3;
    rs2_addr_i = 5'd4; rd_addr_i = 5'd5; pc_i = 32'h100;
`ifdef ID_EX_WB_BYPASS_EN
    wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0;
`endif
    step; check("rst_cyc1_zero", {31'b0, any_out()}, 32'd0);
    step; check("rst_cyc2_zero", {31'b0, any_out()}, 32'd0);

    // Plain load.
    rst_i = 0;
    step;
    check("load_valid",    {31'b0, valid_o},    32'd1);
    check("load_regwrite", {31'b0, RegWrite_o}, 32'd1);
    check("load_memtoreg", {31'b0, MemtoReg_o}, 32'd1);
    check("load_memwrite", {31'b0, MemWrite_o}, 32'd1);
    check("load_alusrc",   {31'b0, ALUSrc_o},   32'd1);
    check("load_aluop",    {30'b0, ALUOp_o},    32'd2);
    check("load_imm",      imm_o,               32'hFFFF_F800);
    check("load_rd",       {27'b0, rd_addr_o},  32'd5);
    check("load_rs1_addr", {27'b0, rs1_addr_o}, 32'd3);
    check("load_rs2_addr", {27'b0, rs2_addr_o}, 32'd4);
    check("load_rs1_data", rs1_data_o,          32'h1111_1111);
    check("load_rs2_data", rs2_data_o,          32'h2222_2222);
    check("load_funct",    {22'b0, funct_o},    32'h2A5);
    check("load_pc",       pc_o,                32'h100);
    check("load_pend",     {31'b0, flush_pend_o}, 32'd0);

    // Load-use bubble, then the same instruction loads.
    nop_i = 1; MemRead_i = 1; rd_addr_i = 5'd7;
    step;
    check("nop_valid",    {31'b0, valid_o},    32'd0);
    check("nop_memread",  {31'b0, MemRead_o},  32'd0);
    check("nop_regwrite", {31'b0, RegWrite_o}, 32'd0);
    check("nop_memwrite", {31'b0, MemWrite_o}, 32'd0);
    check("nop_rd",       {27'b0, rd_addr_o},  32'd0);
    check("nop_imm",      imm_o,               32'd0);
    check("nop_pc",       pc_o,                32'd0);
    nop_i = 0;
    step;
    check("after_nop_valid",   {31'b0, valid_o},   32'd1);
    check("after_nop_memread", {31'b0, MemRead_o}, 32'd1);
    check("after_nop_rd",      {27'b0, rd_addr_o}, 32'd7);

    // valid_i=0 is also a bubble.
    valid_i = 0;
    step;
    check("invalid_valid",    {31'b0, valid_o},    32'd0);
    check("invalid_regwrite", {31'b0, RegWrite_o}, 32'd0);

    // Stall hold: nop_i and valid_i ignored while stalled.
    valid_i = 1; MemRead_i = 0; pc_i = 32'h40;
    step;
    check("pre_stall_pc", pc_o, 32'h40);
    stall_i = 1; pc_i = 32'h44; nop_i = 1;
    for (int i = 0; i < 3; i++) begin
      step;
      check($sformatf("stall_pc_%0d", i), pc_o, 32'h40);
      check($sformatf("stall_valid_%0d", i), {31'b0, valid_o}, 32'd1);
    end
    stall_i = 0; nop_i = 0;
    step;
    check("release_pc", pc_o, 32'h44);

    // Flush arriving with the stall, applied on release.
    stall_i = 1; flush_i = 1;
    step;
    check("fstall_pend_c1", {31'b0, flush_pend_o}, 32'd1);
    check("fstall_pc_c1",   pc_o,                  32'h44);
    flush_i = 0; pc_i = 32'h48;
    step; check("fstall_pend_c2", {31'b0, flush_pend_o}, 32'd1);
    step; check("fstall_pend_c3", {31'b0, flush_pend_o}, 32'd1);
    check("fstall_valid_c3", {31'b0, valid_o}, 32'd1);
    stall_i = 0;
    step;
    check("frel_valid", {31'b0, valid_o},      32'd0);
    check("frel_pend",  {31'b0, flush_pend_o}, 32'd0);
    check("frel_pc",    pc_o,                  32'd0);
    step;
    check("frel_next_valid", {31'b0, valid_o}, 32'd1);
    check("frel_next_pc",    pc_o,             32'h48);

    // Release coinciding with a new flush: exactly one bubble.
    stall_i = 1; flush_i = 1;
    step; check("dbl_pend", {31'b0, flush_pend_o}, 32'd1);
    stall_i = 0; flush_i = 1;
    step;
    check("dbl_bubble_valid", {31'b0, valid_o},      32'd0);
    check("dbl_bubble_pend",  {31'b0, flush_pend_o}, 32'd0);
    flush_i = 0;
    step; check("dbl_single_bubble", {31'b0, valid_o}, 32'd1);

    // Reset in the middle of a stall with a pending flush.
    stall_i = 1; flush_i = 1;
    step;
    check("rstmid_pre_pend",  {31'b0, flush_pend_o}, 32'd1);
    check("rstmid_pre_valid", {31'b0, valid_o},      32'd1);
    rst_i = 1; flush_i = 0;
    step; check("rstmid_zero", {31'b0, any_out()}, 32'd0);
    rst_i = 0; stall_i = 0;

    // Register data capture (and write-through when built in).
    rs1_addr_i = 5'd3; rs1_data_i = 32'h1; rs2_addr_i = 5'd4; rs2_data_i = 32'h2;
`ifdef ID_EX_WB_BYPASS_EN
    wb_we_i = 1; wb_rd_i = 5'd3; wb_data_i = 32'hABCD;
    step;
    check("byp_rs1_hit",  rs1_data_o, 32'hABCD);
    check("byp_rs2_miss", rs2_data_o, 32'h2);
    wb_rd_i = 5'd0; rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;
    step;
    check("byp_x0_rs1", rs1_data_o, 32'h1);
    check("byp_x0_rs2", rs2_data_o, 32'h2);
    wb_rd_i = 5'd4; wb_we_i = 0; rs2_addr_i = 5'd4;
    step;
    check("byp_we0_rs2", rs2_data_o, 32'h2);
    wb_we_i = 1; stall_i = 1;
    step;
    check("byp_stall_hold", rs2_data_o, 32'h2);
    stall_i = 0;
    step;
    check("byp_rs2_hit", rs2_data_o, 32'hABCD);
`else
    step;
    check("direct_rs1", rs1_data_o, 32'h1);
    check("direct_rs2", rs2_data_o, 32'h2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage pipelined RV32 core. Sits directly downstream of the decode stage: the register file, the control unit and the immediate generator.
- Captures decoded control, operand data, the sign-extended immediate, funct bits and register addresses every cycle, for consumption by EX (ALU control, ALU source mux, forwarding unit).
- Handles data-cache stall (freeze), branch flush and hazard bubble insertion.
- A flush that arrives during a stall is remembered and applied when the stall releases.

Parameters:
- XLEN, 32, width of operand data, immediate and PC fields.
- REG_AW, 5, width of register address fields.

Ports:
- clk_i  input  1  core clock; all state updates on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- stall_i  input  1  data-cache memory stall; freezes the register.
- flush_i  input  1  branch-taken flush of the instruction in ID.
- nop_i  input  1  hazard-detection bubble request (load-use).
- valid_i  input  1  ID holds a real instruction.
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i  input  1 each  decoded control.
- ALUOp_i  input  2  ALU operation class.
- rs1_data_i, rs2_data_i  input  XLEN  register file read data.
- imm_i  input  XLEN  sign-extended immediate from the immediate generator.
- funct_i  input  10  {funct7, funct3} = instr[31:25], instr[14:12].
- rs1_addr_i, rs2_addr_i, rd_addr_i  input  REG_AW  register indices.
- pc_i  input  XLEN  PC of the instruction in ID.
- Outputs: same-named *_o registered copies of every field above (RegWrite_o … pc_o).
- valid_o  output  1  EX holds a real instruction.
- flush_pend_o  output  1  a flush is pending behind a stall (debug/verification visibility).

Behaviour:
- Reset: while rst_i=1 at a clock edge, every output including valid_o and flush_pend_o is cleared to 0.
- Latency: one cycle. Inputs sampled at edge N appear on outputs after edge N.
- Per-edge priority: rst_i > stall_i > bubble > load.
- Stall (stall_i=1): all *_o fields and valid_o hold. flush_pend <= flush_pend | flush_i. nop_i and valid_i are ignored.
- Bubble condition (stall_i=0): flush_i | flush_pend | nop_i | !valid_i. On a bubble:
  - all control outputs, valid_o and every data/address/imm/funct/pc output <= 0;
  - flush_pend <= 0.
- Load (stall_i=0, no bubble condition): every *_o <= corresponding *_i, valid_o <= 1, flush_pend <= 0.
- Bubble output is an architectural NOP: RegWrite_o=0, MemWrite_o=0, MemRead_o=0, rd_addr_o=0. The forwarding unit never matches a bubble.
- flush_pend_o = flush_pend register.
- A stall that starts in the same cycle as flush_i still applies the flush, on the first cycle after the stall ends.
- A stall that releases in the same cycle as a new flush_i yields a single bubble, not two.
- Width rules: no arithmetic; pure capture. The imm_i full XLEN value is stored unmodified, including sign bits.
- No combinational path from any input to any output.

Optional Feature:
- Macro: ID_EX_WB_BYPASS_EN.
- When defined: adds inputs wb_we_i (1), wb_rd_i (REG_AW), wb_data_i (XLEN), which provide register-file write-through.
  - On a load cycle, if wb_we_i=1, wb_rd_i!=0 and wb_rd_i==rs1_addr_i, then rs1_data_o <= wb_data_i. The same rule applies independently to rs2.
  - Bypass does not apply on stall or bubble cycles.
- When not defined: those ports do not exist, and rs1/rs2 data are captured directly from rs*_data_i.

Test Plan:
- Reset then load: rst_i=1 for 2 cycles, then valid_i=1, RegWrite_i=1, imm_i=32'hFFFF_F800, rd_addr_i=5 → after one edge: valid_o=1, RegWrite_o=1, imm_o=32'hFFFF_F800, rd_addr_o=5. All outputs were 0 during reset.
- Load-use bubble: nop_i=1 with MemRead_i=1, rd_addr_i=7 → next cycle valid_o=0, MemRead_o=0, rd_addr_o=0. With nop_i=0 on the next cycle, the instruction loads normally.
- Stall hold: load pc_i=32'h40, then stall_i=1 for 3 cycles while pc_i=32'h44 → pc_o stays 32'h40 for all 3 cycles; pc_o=32'h44 after release.
- Flush behind stall: stall_i=1 and flush_i=1 in cycle 1, flush_i=0 in cycles 2–3, stall_i=0 in cycle 4 → flush_pend_o=1 in cycles 2–4. After edge 4: valid_o=0, flush_pend_o=0.
- Reset mid-stall: stall_i=1, flush_pend_o=1, valid_o=1, then rst_i=1 → all outputs 0 after that edge.
- With ID_EX_WB_BYPASS_EN: rs1_addr_i=3, rs1_data_i=32'h1, wb_we_i=1, wb_rd_i=3, wb_data_i=32'hABCD → rs1_data_o=32'hABCD. The same stimulus with wb_rd_i=0 gives rs1_data_o=32'h1.
